// File: rtl/clock_pkg.sv
// Shared definitions for the clock field counters.
// BCD_W is the width of one BCD digit; to_bcd() converts a decimal constant
// into packed BCD (up to four digits, digit 0 in the low nibble);
// bcd_valid() reports whether a single nibble holds a legal BCD digit.
package clock_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 4;

  // Elaboration-time conversion of a decimal integer into packed BCD.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int value);
    logic [BCD_W*MAX_DIGITS-1:0] packed_bcd;
    int rest;
    packed_bcd = '0;
    rest       = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      packed_bcd[BCD_W*i +: BCD_W] = 4'(rest % 10);
      rest = rest / 10;
    end
    return packed_bcd;
  endfunction

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Three-flop synchronizer for a raw active-low push button with a
// falling-edge (press) pulse output.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset; all stages reset to 1 (released)
//   btn   - raw asynchronous button level, active low
//   fall  - one-cycle pulse while stage 2 is low and stage 3 is still high
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic fall
);

  // sync[0] = stage 1 (metastability catcher), sync[1] = stage 2,
  // sync[2] = stage 3 (previous value used for the edge detect).
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b111;
    end else begin
      sync <= {sync[1:0], btn};
    end
  end

  assign fall = ~sync[1] & sync[2];

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD counter with programmable range, cascade
// carry and a button-driven set mode. Chains with a slower field by wiring
// carry_out to the next stage's tick_in.
// Ports:
//   clk       - sole clock, rising edge
//   rst_n     - asynchronous active-low reset
//   tick_in   - run-mode count enable, one-cycle pulse
//   set_ena   - 1 = set mode (buttons step the value), 0 = run mode
//   up_n      - raw active-low increment button
//   down_n    - raw active-low decrement button
//   load_en   - one-cycle parallel-load strobe (honoured in both modes)
//   load_bcd  - packed BCD load value, digit 0 in [3:0]
//   bcd_out   - current value, packed BCD, registered
//   carry_out - combinational: tick_in & ~set_ena & (bcd_out == MAX_VAL)
//   load_err  - registered one-cycle pulse when a load is rejected
module bcd_updown_counter
  import clock_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59,
  parameter int RST_VAL = MIN_VAL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_in,
  input  logic                  set_ena,
  input  logic                  up_n,
  input  logic                  down_n,
  input  logic                  load_en,
  input  logic [BCD_W*DIGITS-1:0] load_bcd,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                  carry_out,
  output logic                  load_err
);

  localparam int W = BCD_W*DIGITS;

  localparam logic [BCD_W*MAX_DIGITS-1:0] MIN_FULL = to_bcd(MIN_VAL);
  localparam logic [BCD_W*MAX_DIGITS-1:0] MAX_FULL = to_bcd(MAX_VAL);
  localparam logic [BCD_W*MAX_DIGITS-1:0] RST_FULL = to_bcd(RST_VAL);

  localparam logic [W-1:0] MIN_BCD = MIN_FULL[W-1:0];
  localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];
  localparam logic [W-1:0] RST_BCD = RST_FULL[W-1:0];

  logic [W-1:0]      bcd_q;
  logic [W-1:0]      bcd_next;
  logic              err_next;
  logic [W-1:0]      inc_val;
  logic [W-1:0]      dec_val;
  logic [DIGITS-1:0] digit_ok;
  logic              at_max;
  logic              at_min;
  logic              load_ok;
  logic              up_fall;
  logic              down_fall;
  logic              step_up;
  logic              step_down;

  btn_edge_sync u_up_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (up_n),
    .fall  (up_fall)
  );

  btn_edge_sync u_down_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (down_n),
    .fall  (down_fall)
  );

  // Digit-serial increment/decrement. A digit receives the ripple carry
  // exactly when every lower digit is 9 (borrow: every lower digit is 0),
  // so each stage's carry-in is expressed directly as that comparison.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [BCD_W-1:0] cur;
    logic             cin;
    logic             bin;

    assign cur = bcd_q[BCD_W*i +: BCD_W];

    if (i == 0) begin : g_lsd
      assign cin = 1'b1;
      assign bin = 1'b1;
    end else begin : g_upper
      assign cin = (bcd_q[BCD_W*i-1:0] == {i{4'h9}});
      assign bin = (bcd_q[BCD_W*i-1:0] == '0);
    end

    assign inc_val[BCD_W*i +: BCD_W] = !cin ? cur :
                                       (cur == 4'd9) ? 4'd0 : cur + 4'd1;
    assign dec_val[BCD_W*i +: BCD_W] = !bin ? cur :
                                       (cur == 4'd0) ? 4'd9 : cur - 4'd1;

    assign digit_ok[i] = bcd_valid(load_bcd[BCD_W*i +: BCD_W]);
  end

  // With every digit legal, packed BCD orders the same as its decimal
  // value, so plain magnitude compares against the BCD bounds suffice.
  assign load_ok = (&digit_ok) && (load_bcd >= MIN_BCD) && (load_bcd <= MAX_BCD);
  assign at_max  = (bcd_q == MAX_BCD);
  assign at_min  = (bcd_q == MIN_BCD);

  // Button edges only matter in set mode; a simultaneous press of both
  // buttons cancels out.
  assign step_up   = set_ena & up_fall & ~down_fall;
  assign step_down = set_ena & down_fall & ~up_fall;

  // Next value: load beats a set-mode step, which beats a run-mode tick.
  always_comb begin
    bcd_next = bcd_q;
    err_next = 1'b0;
    if (load_en) begin
      if (load_ok) begin
        bcd_next = load_bcd;
      end else begin
        err_next = 1'b1;
      end
    end else if (set_ena) begin
      if (step_up) begin
        bcd_next = at_max ? MIN_BCD : inc_val;
      end else if (step_down) begin
        bcd_next = at_min ? MAX_BCD : dec_val;
      end
    end else if (tick_in) begin
      bcd_next = at_max ? MIN_BCD : inc_val;
    end
  end

  // Count register and rejected-load pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q    <= RST_BCD;
      load_err <= 1'b0;
    end else begin
      bcd_q    <= bcd_next;
      load_err <= err_next;
    end
  end

  assign bcd_out   = bcd_q;
  assign carry_out = tick_in & ~set_ena & at_max;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter: a 0..59 seconds
// counter cascaded into a 0..59 minutes counter, plus an independent
// 1..12 hours counter.
module tb_bcd_updown_counter;

  logic       clk;
  logic       rst_n;

  logic       tick_s, set_s, up_s, down_s, load_s;
  logic [7:0] load_bcd_s;
  logic [7:0] bcd_s;
  logic       carry_s, err_s;

  logic [7:0] bcd_m;
  logic       carry_m, err_m;

  logic       tick_h, set_h, up_h, down_h, load_h;
  logic [7:0] load_bcd_h;
  logic [7:0] bcd_h;
  logic       carry_h, err_h;

  int tests_run;
  int tests_failed;
  int min_carries;
  int sec_carries;

  bcd_updown_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(59)) dut_sec (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_in   (tick_s),
    .set_ena   (set_s),
    .up_n      (up_s),
    .down_n    (down_s),
    .load_en   (load_s),
    .load_bcd  (load_bcd_s),
    .bcd_out   (bcd_s),
    .carry_out (carry_s),
    .load_err  (err_s)
  );

  bcd_updown_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(59)) dut_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_in   (carry_s),
    .set_ena   (1'b0),
    .up_n      (1'b1),
    .down_n    (1'b1),
    .load_en   (1'b0),
    .load_bcd  (8'h00),
    .bcd_out   (bcd_m),
    .carry_out (carry_m),
    .load_err  (err_m)
  );

  bcd_updown_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12)) dut_hr (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_in   (tick_h),
    .set_ena   (set_h),
    .up_n      (up_h),
    .down_n    (down_h),
    .load_en   (load_h),
    .load_bcd  (load_bcd_h),
    .bcd_out   (bcd_h),
    .carry_out (carry_h),
    .load_err  (err_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the seconds counter inputs in one call.
  task automatic applyStimulus(input logic ld, input logic [7:0] val,
                               input logic tk, input logic st,
                               input logic up, input logic dn);
    load_s     = ld;
    load_bcd_s = val;
    tick_s     = tk;
    set_s      = st;
    up_s       = up;
    down_s     = dn;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    min_carries  = 0;
    sec_carries  = 0;
    rst_n        = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick_h = 1'b0; set_h = 1'b0; up_h = 1'b1; down_h = 1'b1;
    load_h = 1'b0; load_bcd_h = 8'h00;

    // Reset state.
    waitCycles(3);
    checkOutput("reset_sec", bcd_s, 8'h00);
    checkOutput("reset_carry", carry_s, 1'b0);
    checkOutput("reset_err", err_s, 1'b0);
    checkOutput("reset_min", bcd_m, 8'h00);
    checkOutput("reset_hr", bcd_h, 8'h01);

    rst_n = 1'b1;
    waitCycles(10);
    checkOutput("idle_sec", bcd_s, 8'h00);

    // Run mode across the 59 -> 00 wrap.
    applyStimulus(1'b1, 8'h58, 1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(1);
    checkOutput("load_58", bcd_s, 8'h58);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("carry_at_58", carry_s, 1'b0);
    waitCycles(1);
    checkOutput("tick_59", bcd_s, 8'h59);
    checkOutput("carry_at_59", carry_s, 1'b1);
    waitCycles(1);
    checkOutput("tick_wrap", bcd_s, 8'h00);
    checkOutput("min_cascade", bcd_m, 8'h01);
    tick_s = 1'b0;
    #1;
    checkOutput("carry_idle", carry_s, 1'b0);

    // Set mode: hold down for 100 cycles, exactly one step at edge N+2.
    waitCycles(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("down_edge_n", bcd_s, 8'h00);
    waitCycles(1);
    checkOutput("down_edge_n1", bcd_s, 8'h00);
    waitCycles(1);
    checkOutput("down_edge_n2", bcd_s, 8'h59);
    tick_s = 1'b1;
    #1;
    checkOutput("set_carry_forced0", carry_s, 1'b0);
    waitCycles(97);
    checkOutput("down_held", bcd_s, 8'h59);
    checkOutput("set_tick_ignored_carry", carry_s, 1'b0);
    tick_s = 1'b0;
    down_s = 1'b1;
    waitCycles(5);
    checkOutput("down_release", bcd_s, 8'h59);

    // Both buttons pressed on the same cycle cancel out.
    up_s   = 1'b0;
    down_s = 1'b0;
    waitCycles(6);
    checkOutput("both_pressed", bcd_s, 8'h59);
    up_s   = 1'b1;
    down_s = 1'b1;
    waitCycles(5);

    // Up press wraps 59 -> 00.
    up_s = 1'b0;
    waitCycles(3);
    checkOutput("up_wrap", bcd_s, 8'h00);
    waitCycles(4);
    checkOutput("up_held", bcd_s, 8'h00);
    up_s = 1'b1;
    waitCycles(5);

    // A button press in run mode is discarded.
    set_s  = 1'b0;
    up_s   = 1'b0;
    waitCycles(5);
    checkOutput("run_button_ignored", bcd_s, 8'h00);
    up_s = 1'b1;
    waitCycles(5);

    // Loads: illegal digit, out of range, then valid.
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(1);
    checkOutput("load_5A_err", err_s, 1'b1);
    checkOutput("load_5A_kept", bcd_s, 8'h00);
    load_s = 1'b0;
    waitCycles(1);
    checkOutput("load_err_oneshot", err_s, 1'b0);
    applyStimulus(1'b1, 8'h60, 1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(1);
    checkOutput("load_60_err", err_s, 1'b1);
    checkOutput("load_60_kept", bcd_s, 8'h00);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(1);
    checkOutput("load_42", bcd_s, 8'h42);
    checkOutput("load_42_err", err_s, 1'b0);
    load_s = 1'b0;

    // Load honoured in set mode.
    applyStimulus(1'b1, 8'h17, 1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(1);
    checkOutput("load_set_mode", bcd_s, 8'h17);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Hours configuration 1..12.
    load_h = 1'b1; load_bcd_h = 8'h00;
    waitCycles(1);
    checkOutput("hr_load_00_err", err_h, 1'b1);
    checkOutput("hr_load_00_kept", bcd_h, 8'h01);
    load_bcd_h = 8'h12;
    waitCycles(1);
    checkOutput("hr_load_12", bcd_h, 8'h12);
    load_h = 1'b0;
    tick_h = 1'b1;
    #1;
    checkOutput("hr_carry_12", carry_h, 1'b1);
    waitCycles(1);
    checkOutput("hr_wrap", bcd_h, 8'h01);
    tick_h = 1'b0;
    set_h  = 1'b1;
    down_h = 1'b0;
    waitCycles(3);
    checkOutput("hr_down_wrap", bcd_h, 8'h12);
    checkOutput("hr_set_carry", carry_h, 1'b0);
    down_h = 1'b1;
    set_h  = 1'b0;
    waitCycles(3);

    // Cascade: 3600 ticks from 00:00 return to 00:00.
    rst_n = 1'b0;
    #1;
    checkOutput("casc_reset_sec", bcd_s, 8'h00);
    checkOutput("casc_reset_min", bcd_m, 8'h00);
    waitCycles(1);
    rst_n  = 1'b1;
    tick_s = 1'b1;
    #1;
    for (int i = 0; i < 3600; i++) begin
      if (carry_m) min_carries++;
      if (carry_s) sec_carries++;
      waitCycles(1);
    end
    checkOutput("casc_sec", bcd_s, 8'h00);
    checkOutput("casc_min", bcd_m, 8'h00);
    checkOutput("casc_min_carries", min_carries, 1);
    checkOutput("casc_sec_carries", sec_carries, 60);

    // Asynchronous reset mid-count.
    waitCycles(65);
    checkOutput("pre_reset_sec", bcd_s, 8'h05);
    checkOutput("pre_reset_min", bcd_m, 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_sec", bcd_s, 8'h00);
    checkOutput("async_reset_min", bcd_m, 8'h00);
    checkOutput("async_reset_hr", bcd_h, 8'h01);

    // First count at the first edge after release.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("first_after_reset", bcd_s, 8'h01);
    tick_s = 1'b0;
    waitCycles(2);
    checkOutput("min_err_quiet", err_m, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
